// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: frame geometry, the
// scheduler state encoding and the frame hold-off helper. The helper is a
// plain function so benches and other UART blocks can size their timing
// from the same formula as the RTL.
// ----------------------------------------------------------------------------
package uart_pkg;

    // start + 8 data + 2 stop
    localparam int UART_FRAME_BITS = 11;

    // Scheduler states kept as plain 2-bit constants so existing tooling
    // that decodes the state bus keeps working.
    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_ISSUE = 2'd1;
    localparam sched_state_t ST_WAIT  = 2'd2;

    // Clocks to hold off after a tx_request pulse: one full frame at
    // (clk_div+1) clocks per bit plus a two-cycle guard.
    function automatic int frame_cycles(input int clk_div);
        return UART_FRAME_BITS * (clk_div + 1) + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts one position
// after ptr and wraps modulo NUM_REQ; the first requesting index wins.
//
// Ports
//   req      in   NUM_REQ  request vector
//   ptr      in   IDX_W    index of the previous winner
//   enable   in   1        when low, no grant is produced
//   gnt      out  NUM_REQ  one-hot grant, or zero
//   gnt_idx  out  IDX_W    index of the granted requester (0 when none)
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    logic found;
    int   cand;

    // NOTE: every signal written here gets a default before the search so
    // no path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        // Outer loop walks priority order ptr+1, ptr+2, ...; the inner loop
        // keeps every bit select constant after unrolling.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enable && !found && req[i] && (cand == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IDX_W'(i);
                    found   = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmitter among NUM_REQ byte producers. Requesters are
// served round-robin; a requester may hold req_lock to keep the grant across
// a multi-byte message. Each accepted byte produces exactly one single-cycle
// uart_tx_request pulse, after which the block waits out the frame time
// itself because the transmitter reports no busy status.
//
// Ports
//   clk              in   1          rising-edge clock
//   reset            in   1          asynchronous active-low reset
//   req_valid        in   NUM_REQ    requester i has a byte available
//   req_data         in   8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_lock         in   NUM_REQ    requester i keeps the grant after this byte
//   req_ready        out  NUM_REQ    combinational accept, one-hot or zero
//   uart_tx_data     out  8          byte to the UART, stable between issues
//   uart_tx_request  out  1          one-cycle start pulse to the UART
//   busy             out  1          a frame is being issued or waited out
//   grant_id         out  3          index of the last accepted requester
// ----------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CLK_RATE     = 12000000,
    parameter int BAUD_RATE    = 9600,
    parameter int CLK_DIV      = CLK_RATE / BAUD_RATE,
    parameter int FRAME_CYCLES = frame_cycles(CLK_DIV)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_lock,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_tx_data,
    output logic                   uart_tx_request,
    output logic                   busy,
    output logic [2:0]             grant_id
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FRAME_CYCLES + 1);

    // Refuse configurations the 3-bit grant_id or the bit timing cannot serve.
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("uart_tx_scheduler: NUM_REQ must be within 2..8");
    end
    if (CLK_DIV < 2 || BAUD_RATE <= 0 || CLK_RATE <= 0) begin : g_bad_clk_div
        $error("uart_tx_scheduler: CLK_DIV must be at least 2");
    end

    sched_state_t        state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    lock_owner;
    logic                lock_valid;
    logic [IDX_W-1:0]    grant_q;
    logic [CNT_W-1:0]    counter;

    logic [NUM_REQ-1:0]  owner_mask;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDX_W-1:0]    win_idx;
    logic [7:0]          win_data;
    logic                lock_held;
    logic                win_lock;
    logic                arb_en;
    logic                accept;

    // ------------------------------------------------------------------
    // Lock masking. A lock only counts while its owner still drives
    // req_lock; once dropped in IDLE the round-robin search applies in the
    // same cycle. While the lock holds, the owner is the only eligible
    // requester even if it currently has nothing to send.
    // ------------------------------------------------------------------
    always_comb begin
        owner_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_mask[i] = (lock_owner == IDX_W'(i));
        end
    end

    assign lock_held = lock_valid && |(req_lock & owner_mask);
    assign eligible  = lock_held ? (req_valid & owner_mask) : req_valid;

    // reset is folded in so req_ready stays low while reset is asserted.
    assign arb_en = (state == ST_IDLE) && reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req     (eligible),
        .ptr     (rr_ptr),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (win_idx)
    );

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign win_lock  = |(req_lock & gnt);

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                win_data = req_data[i*8 +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM and frame counter. The counter is loaded on the accept
    // edge and only counts down in WAIT, so a frame keeps the block busy
    // for one ISSUE cycle plus FRAME_CYCLES WAIT cycles.
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_IDLE;
            uart_tx_request <= 1'b0;
            uart_tx_data    <= 8'h00;
            grant_q         <= '0;
            rr_ptr          <= IDX_W'(NUM_REQ - 1);
            lock_valid      <= 1'b0;
            lock_owner      <= '0;
            counter         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        uart_tx_data    <= win_data;
                        uart_tx_request <= 1'b1;
                        grant_q         <= win_idx;
                        rr_ptr          <= win_idx;
                        lock_valid      <= win_lock;
                        lock_owner      <= win_idx;
                        counter         <= CNT_W'(FRAME_CYCLES - 1);
                        state           <= ST_ISSUE;
                    end else if (lock_valid && !lock_held) begin
                        lock_valid <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    uart_tx_request <= 1'b0;
                    state           <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (counter == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                default: begin
                    uart_tx_request <= 1'b0;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign grant_id = 3'(grant_q);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Producers feed per-requester byte queues into the scheduler. A reference
// model predicts, cycle by cycle, which requester should be accepted and
// pushes the expected issue into a scoreboard; a monitor pops it when the
// scheduler pulses uart_tx_request. A UART model serialises the issued
// bytes onto a line and a decoder checks each frame against the bytes the
// reference model expects on the wire.
// ----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NUM_REQ   = 4;
    localparam int CLK_DIV   = 4;
    localparam int BIT_CYC   = CLK_DIV + 1;
    localparam int FRAME_CYC = 11 * BIT_CYC + 2;   // 57
    localparam int BOUND     = 20000;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [8*NUM_REQ-1:0]  req_data;
    logic [NUM_REQ-1:0]    req_lock;
    logic [NUM_REQ-1:0]    req_ready;
    logic [7:0]            uart_tx_data;
    logic                  uart_tx_request;
    logic                  busy;
    logic [2:0]            grant_id;

    uart_tx_scheduler #(
        .NUM_REQ (NUM_REQ),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_data        (req_data),
        .req_lock        (req_lock),
        .req_ready       (req_ready),
        .uart_tx_data    (uart_tx_data),
        .uart_tx_request (uart_tx_request),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Producers: one queue of {lock, data} per requester.
    // ------------------------------------------------------------------
    logic [8:0]         prod_q [NUM_REQ][$];
    logic [NUM_REQ-1:0] lock_idle;   // req_lock level when a producer has no byte
    logic [NUM_REQ-1:0] acc_mask = '0;

    always @(negedge clk) acc_mask = req_valid & req_ready;

    task automatic update_drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (prod_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = prod_q[i][0][7:0];
                req_lock[i]        = prod_q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_lock[i]  = lock_idle[i];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_mask[i] && prod_q[i].size() > 0) void'(prod_q[i].pop_front());
        end
        update_drive();
    endtask

    task automatic push(input int id, input logic [7:0] data, input logic lock);
        prod_q[id].push_back({lock, data});
        update_drive();
    endtask

    function automatic bit producers_empty();
        for (int i = 0; i < NUM_REQ; i++) if (prod_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: the block is free again FRAME_CYC+2 cycles after an
    // accept cycle (one ISSUE cycle plus FRAME_CYC WAIT cycles in between).
    // When free, a live lock restricts the choice to its owner, otherwise
    // the next valid requester after the last winner is chosen.
    // ------------------------------------------------------------------
    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       issue_q [$];
    logic [7:0] line_q  [$];

    int free_at   = 0;
    int last_w    = NUM_REQ - 1;
    int lock_hold = -1;

    always @(negedge clk) begin
        int                 cand;
        bit                 idle;
        logic [NUM_REQ-1:0] exp_ready;
        if (!reset) begin
            free_at   = 0;
            last_w    = NUM_REQ - 1;
            lock_hold = -1;
            issue_q.delete();
            line_q.delete();
            check("ready_in_reset", 32'(req_ready), 0);
            check("busy_in_reset", 32'(busy), 0);
        end else begin
            idle = (cyc >= free_at);
            check("busy", 32'(busy), 32'(!idle));
            cand = -1;
            if (idle) begin
                if (lock_hold >= 0 && !req_lock[lock_hold]) lock_hold = -1;
                if (lock_hold >= 0) begin
                    if (req_valid[lock_hold]) cand = lock_hold;
                end else begin
                    for (int k = 1; k <= NUM_REQ && cand < 0; k++) begin
                        if (req_valid[(last_w + k) % NUM_REQ]) cand = (last_w + k) % NUM_REQ;
                    end
                end
            end
            exp_ready = '0;
            if (cand >= 0) exp_ready[cand] = 1'b1;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            if (cand >= 0) begin
                issue_q.push_back('{cyc: cyc + 1, id: cand, data: req_data[cand*8 +: 8]});
                line_q.push_back(req_data[cand*8 +: 8]);
                last_w    = cand;
                lock_hold = req_lock[cand] ? cand : -1;
                free_at   = cyc + FRAME_CYC + 2;
            end
        end
    end

    // ------------------------------------------------------------------
    // UART model: loads on a request pulse, then drives start, 8 data bits
    // LSB first and two stop bits, BIT_CYC clocks each.
    // ------------------------------------------------------------------
    logic        line = 1'b1;
    logic        ser_busy = 1'b0;
    logic [10:0] ser_sh;
    int          ser_bit;
    int          ser_tick;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            ser_busy <= 1'b0;
            line     <= 1'b1;
            ser_bit  <= 0;
            ser_tick <= 0;
            ser_sh   <= '0;
        end else if (uart_tx_request) begin
            ser_sh   <= {2'b11, uart_tx_data, 1'b0};
            ser_busy <= 1'b1;
            ser_bit  <= 0;
            ser_tick <= 0;
            line     <= 1'b0;
        end else if (ser_busy) begin
            if (ser_tick == CLK_DIV) begin
                ser_tick <= 0;
                if (ser_bit == 10) begin
                    ser_busy <= 1'b0;
                    line     <= 1'b1;
                end else begin
                    ser_bit <= ser_bit + 1;
                    line    <= ser_sh[ser_bit + 1];
                end
            end else begin
                ser_tick <= ser_tick + 1;
            end
        end
    end

    // Line decoder: samples each bit in the middle of its bit time.
    bit          dec_active = 1'b0;
    int          dec_cnt    = 0;
    logic [10:0] dec_frame;

    always @(negedge clk) begin
        if (!reset) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (line == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt    = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % BIT_CYC == BIT_CYC / 2) begin
                dec_frame[dec_cnt / BIT_CYC] = line;
                if (dec_cnt / BIT_CYC == 10) begin
                    dec_active = 1'b0;
                    check("frame_start_bit", 32'(dec_frame[0]), 0);
                    check("frame_stop_bits", 32'(dec_frame[10:9]), 32'h3);
                    check("frame_expected", 32'(line_q.size() != 0), 1);
                    if (line_q.size() != 0) check("line_byte", 32'(dec_frame[8:1]), 32'(line_q.pop_front()));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue monitor: pops the scoreboard whenever a request pulse is seen.
    // ------------------------------------------------------------------
    logic prev_req = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_req = 1'b0;
        end else begin
            if (uart_tx_request === 1'b1) begin
                check("request_single_cycle", 32'(prev_req), 0);
                check("uart_free_at_issue", 32'(ser_busy), 0);
                check("issue_expected", 32'(issue_q.size() != 0), 1);
                if (issue_q.size() != 0) begin
                    e = issue_q.pop_front();
                    check("issue_cycle", 32'(cyc), 32'(e.cyc));
                    check("issue_grant_id", 32'(grant_id), 32'(e.id));
                    check("issue_data", 32'(uart_tx_data), 32'(e.data));
                end
            end
            prev_req = uart_tx_request;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drain();
        int n = 0;
        while ((!producers_empty() || busy !== 1'b0) && n < BOUND) begin
            tick();
            n++;
        end
        check("drain_in_time", 32'(n < BOUND), 1);
        repeat (4) tick();
    endtask

    task automatic wait_busy();
        int n = 0;
        while (busy !== 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        check("busy_in_time", 32'(n < BOUND), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        reset     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_lock  = '0;
        lock_idle = '0;
        repeat (3) tick();
        check("reset_tx_request", 32'(uart_tx_request), 0);
        check("reset_tx_data", 32'(uart_tx_data), 0);
        check("reset_grant_id", 32'(grant_id), 0);
        check("reset_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();

        // 1: single byte from requester 0
        push(0, 8'hA5, 1'b0);
        drain();

        // 2: all four requesters valid from reset rotate 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) push(i, 8'h10 + 8'(i), 1'b0);
        push(0, 8'h10, 1'b0);
        drain();

        // 3: requester 1 locks for three bytes while 0 and 2 compete
        push(1, 8'hB0, 1'b1);
        push(1, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b0);
        push(0, 8'hC0, 1'b0);
        push(0, 8'hC1, 1'b0);
        push(2, 8'hD0, 1'b0);
        push(2, 8'hD1, 1'b0);
        drain();

        // 4: lock owner goes idle and blocks requester 0 until it unlocks
        lock_idle[3] = 1'b1;
        push(3, 8'h30, 1'b1);
        n = 0;
        while (prod_q[3].size() != 0 && n < BOUND) begin
            tick();
            n++;
        end
        check("lock_owner_taken", 32'(n < BOUND), 1);
        push(0, 8'h40, 1'b0);
        repeat (200) tick();
        check("blocked_by_idle_owner", 32'(prod_q[0].size()), 1);
        lock_idle[3] = 1'b0;
        update_drive();
        drain();

        // 5: reset 20 cycles into WAIT, then requester 2 accepted at once
        push(2, 8'h55, 1'b0);
        wait_busy();
        repeat (21) tick();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_tx_request", 32'(uart_tx_request), 0);
        check("async_reset_busy", 32'(busy), 0);
        check("async_reset_grant_id", 32'(grant_id), 0);
        check("async_reset_ready", 32'(req_ready), 0);
        repeat (2) tick();
        reset = 1'b1;
        push(2, 8'h66, 1'b0);
        drain();

        // 6: a request raised mid-frame waits for IDLE and is sent once
        push(1, 8'h71, 1'b0);
        wait_busy();
        repeat (10) tick();
        push(3, 8'h83, 1'b0);
        drain();

        // Randomised traffic with occasional locks
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 70)) tick();
            push(int'($urandom_range(0, NUM_REQ - 1)), 8'($urandom), ($urandom_range(0, 3) == 0));
        end
        drain();
        repeat (70) tick();

        check("issue_queue_empty", 32'(issue_q.size()), 0);
        check("line_queue_empty", 32'(line_q.size()), 0);
        check("producers_drained", 32'(producers_empty()), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
